alu_issue_seq: RTL and testbench
================================

// Module: alu_issue_seq
// PURPOSE
// - Issue side of the ALU: takes decoded MIPS fields plus operands over a valid/ready request.
// - Maps them to the 4-bit ALU ctl, drives the ALU's a/b/ctl inputs and captures out/z.
// - Returns result, branch decision and error flag over a valid/ready response.
// - Sits between the multicycle control path and the combinational ALU.
// PARAMETERS
// - W  32  datapath width; ALU operands and result. Shift logic assumes W=32.
// PORTS
// - clk          in   1   clock; all state updates on posedge
// - reset        in   1   synchronous, active-high reset
// - req_valid    in   1   request offered
// - req_ready    out  1   high only in IDLE
// - req_opcode   in   6   instruction[31:26]
// - req_funct    in   6   instruction[5:0]
// - req_shamt    in   5   instruction[10:6]
// - req_rs       in   W   rs operand value
// - req_rt       in   W   rt operand value
// - rsp_valid    out  1   response held until accepted
// - rsp_ready    in   1   consumer accepts response
// - rsp_result   out  W   ALU result
// - rsp_taken    out  1   branch decision
// - rsp_err      out  1   unsupported opcode/funct
// - alu_ctl      out  4   to ALU ctl
// - alu_a        out  W   to ALU a
// - alu_b        out  W   to ALU b
// - alu_out      in   W   from ALU out
// - alu_z        in   1   from ALU z
// BEHAVIOUR
// - Decode, applied at request accept:
//   - R-type, opcode 000000: funct 100000 add->0010; 100010 sub->0110; 100100 and->0000; 100101 or->0001; 100110 xor->1101; 100111 nor->1100; 101010 slt->0111.
//   - 000100 beq: ctl 0110, taken=alu_z.
//   - 000101 bne: ctl 0110, taken=~alu_z.
//   - Every other case sets err.
// - ALU drive: a=rs, b=rt, both from registers latched at accept.
//   - alu_* change only on accept or a SHIFT step; never combinational from req_*.
// - FSM states: IDLE, EXEC, SHIFT, RESP.
//   - IDLE: req_ready=1. On req_valid, latch fields. Go to EXEC, or to RESP with err=1 if decode fails.
//   - EXEC: one cycle. At the edge leaving EXEC, rsp_result<=alu_out and rsp_taken<=(branch ? decision : 0). Go to RESP.
//   - RESP: rsp_valid=1 and outputs stable until rsp_ready. The accept edge goes to IDLE. No new request in the same cycle.
// - Latency: accept at edge N gives rsp_valid from N+2; decode error gives rsp_valid from N+1.
// - Throughput: at most one op per 3 cycles.
// - Error response: rsp_result=0, rsp_taken=0, rsp_err=1. The ALU is not exercised.
// - Arithmetic: results come from the ALU unmodified. No overflow trap. Wrap-around passes through.
// - Reset:
//   - state=IDLE; rsp_valid, rsp_taken, rsp_err = 0; rsp_result = 0.
//   - alu_ctl=0000; alu_a, alu_b = 0; shift counter = 0.
//   - Reset mid-operation abandons it with no response.
// - req_valid outside IDLE is ignored; the requester must hold it until req_ready.
// CONFIGURATION
// - ALU_ISSUE_SLL_EN defined: R-type funct 000000 (sll rd, rt, shamt) is supported.
//   - Accept latches acc=rt and cnt=shamt.
//   - shamt=0: EXEC with ctl 0001, a=rt, b=0; result=rt, so nop returns 0.
//   - shamt>0: SHIFT state for shamt cycles. Each cycle ctl=0010, a=b=acc, acc<=alu_out, cnt--.
//   - When cnt reaches 0, result=acc; go to RESP. Latency is shamt+2 to rsp_valid.
// - ALU_ISSUE_SLL_EN undefined: funct 000000 is a decode error and the SHIFT state is absent.
// TESTING
// - add: rs=7, rt=5, rsp_ready=1 -> rsp_valid at accept+2, result=12, taken=0, err=0; alu_ctl=0010 in EXEC.
// - slt: rs=FFFFFFFF, rt=1 -> result=1. sub with rs=0, rt=1 -> result=FFFFFFFF.
// - beq rs=rt=42 -> taken=1. bne rs=rt=42 -> taken=0. beq rs=1, rt=2 -> taken=0.
// - opcode 100011 (lw) -> rsp_valid at accept+1, err=1, result=0.
// - Hold rsp_ready=0 for 5 cycles -> rsp_valid and result stable, req_ready=0. The second request is accepted only after the response handshake.
// - With ALU_ISSUE_SLL_EN, sll rt=3, shamt=4 -> result=48 at accept+6; without it -> err=1.
// - Assert reset in EXEC -> next cycle state IDLE, rsp_valid=0, req_ready=1.

Source files
------------

// File: rtl/alu_issue_seq_if.sv
// Request, response and ALU-drive signals of alu_issue_seq. The sequencer is the slave; requester and ALU are the master.
interface alu_issue_seq_if #(parameter int W = 32);
  logic         req_valid;
  logic         req_ready;
  logic [5:0]   req_opcode;
  logic [5:0]   req_funct;
  logic [4:0]   req_shamt;
  logic [W-1:0] req_rs;
  logic [W-1:0] req_rt;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_taken;
  logic         rsp_err;
  logic [3:0]   alu_ctl;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_out;
  logic         alu_z;

  modport slave (
    input  req_valid, req_opcode, req_funct, req_shamt, req_rs, req_rt,
    output req_ready,
    output rsp_valid, rsp_result, rsp_taken, rsp_err,
    input  rsp_ready,
    output alu_ctl, alu_a, alu_b,
    input  alu_out, alu_z
  );

  modport master (
    output req_valid, req_opcode, req_funct, req_shamt, req_rs, req_rt,
    input  req_ready,
    input  rsp_valid, rsp_result, rsp_taken, rsp_err,
    output rsp_ready,
    input  alu_ctl, alu_a, alu_b,
    output alu_out, alu_z
  );
endinterface

// File: rtl/alu_issue_seq.sv
// ALU issue sequencer: decodes MIPS fields to ALU ctl, result 2 cycles after accept (1 on decode error, shamt+2 for sll with ALU_ISSUE_SLL_EN).
// Backpressure: req_ready only in IDLE; the response is held stable in RESP until rsp_ready.
module alu_issue_seq #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  alu_issue_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    RESP  = 2'd2
`ifdef ALU_ISSUE_SLL_EN
    ,SHIFT = 2'd3
`endif
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] rsp_result_q, rsp_result_d;
  logic         rsp_taken_q, rsp_taken_d;
  logic         rsp_err_q, rsp_err_d;
  logic [3:0]   alu_ctl_q, alu_ctl_d;
  logic [W-1:0] alu_a_q, alu_a_d;
  logic [W-1:0] alu_b_q, alu_b_d;
  logic         branch_q, branch_d;
  logic         bne_q, bne_d;

  logic         dec_ok;
  logic [3:0]   dec_ctl;
  logic         dec_branch;
  logic         dec_bne;
`ifdef ALU_ISSUE_SLL_EN
  logic         dec_sll;
  logic [4:0]   cnt_q, cnt_d;
`else
  logic         unused_shamt;
  assign unused_shamt = ^bus.req_shamt;
`endif

  always_comb begin
    dec_ok     = 1'b1;
    dec_ctl    = 4'b0000;
    dec_branch = 1'b0;
    dec_bne    = 1'b0;
`ifdef ALU_ISSUE_SLL_EN
    dec_sll    = 1'b0;
`endif
    case (bus.req_opcode)
      6'b000000: begin
        case (bus.req_funct)
          6'b100000: dec_ctl = 4'b0010;
          6'b100010: dec_ctl = 4'b0110;
          6'b100100: dec_ctl = 4'b0000;
          6'b100101: dec_ctl = 4'b0001;
          6'b100110: dec_ctl = 4'b1101;
          6'b100111: dec_ctl = 4'b1100;
          6'b101010: dec_ctl = 4'b0111;
`ifdef ALU_ISSUE_SLL_EN
          6'b000000: begin
            dec_sll = 1'b1;
            dec_ctl = (bus.req_shamt == 5'd0) ? 4'b0001 : 4'b0010;
          end
`endif
          default:   dec_ok  = 1'b0;
        endcase
      end
      6'b000100: begin
        dec_ctl    = 4'b0110;
        dec_branch = 1'b1;
      end
      6'b000101: begin
        dec_ctl    = 4'b0110;
        dec_branch = 1'b1;
        dec_bne    = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    rsp_result_d = rsp_result_q;
    rsp_taken_d  = rsp_taken_q;
    rsp_err_d    = rsp_err_q;
    alu_ctl_d    = alu_ctl_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    branch_d     = branch_q;
    bne_d        = bne_q;
`ifdef ALU_ISSUE_SLL_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          rsp_result_d = '0;
          rsp_taken_d  = 1'b0;
          branch_d     = dec_branch;
          bne_d        = dec_bne;
          if (!dec_ok) begin
            // ALU registers are left untouched on a decode error
            rsp_err_d = 1'b1;
            state_d   = RESP;
          end else begin
            rsp_err_d = 1'b0;
            alu_ctl_d = dec_ctl;
            alu_a_d   = bus.req_rs;
            alu_b_d   = bus.req_rt;
            state_d   = EXEC;
`ifdef ALU_ISSUE_SLL_EN
            if (dec_sll) begin
              alu_a_d = bus.req_rt;
              cnt_d   = bus.req_shamt;
              if (bus.req_shamt == 5'd0) begin
                alu_b_d = '0;
              end else begin
                state_d = SHIFT;
              end
            end
`endif
          end
        end
      end
      EXEC: begin
        rsp_result_d = bus.alu_out;
        rsp_taken_d  = branch_q & (bus.alu_z ^ bne_q);
        state_d      = RESP;
      end
`ifdef ALU_ISSUE_SLL_EN
      SHIFT: begin
        // alu_a_q doubles as the shift accumulator; each step adds it to itself
        alu_a_d = bus.alu_out;
        alu_b_d = bus.alu_out;
        cnt_d   = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          alu_ctl_d = 4'b0001;
          alu_b_d   = '0;
          state_d   = EXEC;
        end
      end
`endif
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rsp_result_q <= '0;
      rsp_taken_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      alu_ctl_q    <= 4'b0000;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      branch_q     <= 1'b0;
      bne_q        <= 1'b0;
`ifdef ALU_ISSUE_SLL_EN
      cnt_q        <= 5'd0;
`endif
    end else begin
      state_q      <= state_d;
      rsp_result_q <= rsp_result_d;
      rsp_taken_q  <= rsp_taken_d;
      rsp_err_q    <= rsp_err_d;
      alu_ctl_q    <= alu_ctl_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      branch_q     <= branch_d;
      bne_q        <= bne_d;
`ifdef ALU_ISSUE_SLL_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_taken  = rsp_taken_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.alu_ctl    = alu_ctl_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq with a behavioural MIPS ALU; honours ALU_ISSUE_SLL_EN.
module tb_alu_issue_seq;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [31:0] alu_res;

  alu_issue_seq_if #(.W(32)) intf ();

  alu_issue_seq #(.W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_res = 32'd0;
    case (intf.alu_ctl)
      4'b0000: alu_res = intf.alu_a & intf.alu_b;
      4'b0001: alu_res = intf.alu_a | intf.alu_b;
      4'b0010: alu_res = intf.alu_a + intf.alu_b;
      4'b0110: alu_res = intf.alu_a - intf.alu_b;
      4'b0111: alu_res = ($signed(intf.alu_a) < $signed(intf.alu_b)) ? 32'd1 : 32'd0;
      4'b1100: alu_res = ~(intf.alu_a | intf.alu_b);
      4'b1101: alu_res = intf.alu_a ^ intf.alu_b;
      default: alu_res = 32'd0;
    endcase
  end
  assign intf.alu_out = alu_res;
  assign intf.alu_z   = (alu_res == 32'd0);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] sh, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [3:0] exp_ctl, input int exp_lat, input logic [31:0] exp_res,
                       input logic exp_tk, input logic exp_err);
    int lat;
    chk({tag, "_idle_ready"}, 32'(intf.req_ready), 32'd1);
    intf.req_opcode = op;
    intf.req_funct  = fn;
    intf.req_shamt  = sh;
    intf.req_rs     = rs;
    intf.req_rt     = rt;
    intf.req_valid  = 1'b1;
    step();
    intf.req_valid  = 1'b0;
    chk({tag, "_ctl"}, 32'(intf.alu_ctl), 32'(exp_ctl));
    lat = 1;
    while (!intf.rsp_valid && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_result"}, intf.rsp_result, exp_res);
    chk({tag, "_taken"}, 32'(intf.rsp_taken), 32'(exp_tk));
    chk({tag, "_err"}, 32'(intf.rsp_err), 32'(exp_err));
    step();
    chk({tag, "_done"}, 32'(intf.rsp_valid), 32'd0);
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    reset           = 1'b1;
    intf.req_valid  = 1'b0;
    intf.req_opcode = 6'd0;
    intf.req_funct  = 6'd0;
    intf.req_shamt  = 5'd0;
    intf.req_rs     = 32'd0;
    intf.req_rt     = 32'd0;
    intf.rsp_ready  = 1'b1;
    step();
    step();
    chk("rst_req_ready", 32'(intf.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(intf.rsp_valid), 32'd0);
    chk("rst_result", intf.rsp_result, 32'd0);
    chk("rst_taken", 32'(intf.rsp_taken), 32'd0);
    chk("rst_err", 32'(intf.rsp_err), 32'd0);
    chk("rst_alu_ctl", 32'(intf.alu_ctl), 32'd0);
    chk("rst_alu_a", intf.alu_a, 32'd0);
    chk("rst_alu_b", intf.alu_b, 32'd0);
    reset = 1'b0;
    step();

    do_op("add", 6'b000000, 6'b100000, 5'd0, 32'd7, 32'd5, 4'b0010, 2, 32'd12, 1'b0, 1'b0);
    do_op("slt", 6'b000000, 6'b101010, 5'd0, 32'hFFFF_FFFF, 32'd1, 4'b0111, 2, 32'd1, 1'b0, 1'b0);
    do_op("sub", 6'b000000, 6'b100010, 5'd0, 32'd0, 32'd1, 4'b0110, 2, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op("beq_eq", 6'b000100, 6'b000000, 5'd0, 32'd42, 32'd42, 4'b0110, 2, 32'd0, 1'b1, 1'b0);
    do_op("bne_eq", 6'b000101, 6'b000000, 5'd0, 32'd42, 32'd42, 4'b0110, 2, 32'd0, 1'b0, 1'b0);
    do_op("beq_ne", 6'b000100, 6'b000000, 5'd0, 32'd1, 32'd2, 4'b0110, 2, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op("bne_ne", 6'b000101, 6'b000000, 5'd0, 32'd1, 32'd2, 4'b0110, 2, 32'hFFFF_FFFF, 1'b1, 1'b0);
    do_op("lw_err", 6'b100011, 6'b000000, 5'd0, 32'd9, 32'd9, 4'b0110, 1, 32'd0, 1'b0, 1'b1);
    chk("lw_alu_a_untouched", intf.alu_a, 32'd1);
    do_op("funct_err", 6'b000000, 6'b111111, 5'd0, 32'd3, 32'd4, 4'b0110, 1, 32'd0, 1'b0, 1'b1);
`ifdef ALU_ISSUE_SLL_EN
    do_op("sll4", 6'b000000, 6'b000000, 5'd4, 32'd9, 32'd3, 4'b0010, 6, 32'd48, 1'b0, 1'b0);
    do_op("sll_nop", 6'b000000, 6'b000000, 5'd0, 32'd9, 32'd0, 4'b0001, 2, 32'd0, 1'b0, 1'b0);
    do_op("sll0", 6'b000000, 6'b000000, 5'd0, 32'd9, 32'd5, 4'b0001, 2, 32'd5, 1'b0, 1'b0);
`else
    do_op("sll_err", 6'b000000, 6'b000000, 5'd4, 32'd9, 32'd3, 4'b0110, 1, 32'd0, 1'b0, 1'b1);
`endif
    do_op("and", 6'b000000, 6'b100100, 5'd0, 32'h0000_F0F0, 32'h0000_FF00, 4'b0000, 2, 32'h0000_F000, 1'b0, 1'b0);
    do_op("or", 6'b000000, 6'b100101, 5'd0, 32'h0000_F0F0, 32'h0000_FF00, 4'b0001, 2, 32'h0000_FFF0, 1'b0, 1'b0);
    do_op("xor", 6'b000000, 6'b100110, 5'd0, 32'h0000_F0F0, 32'h0000_FF00, 4'b1101, 2, 32'h0000_0FF0, 1'b0, 1'b0);
    do_op("nor", 6'b000000, 6'b100111, 5'd0, 32'h0000_F0F0, 32'h0000_FF00, 4'b1100, 2, 32'hFFFF_000F, 1'b0, 1'b0);
    do_op("add_wrap", 6'b000000, 6'b100000, 5'd0, 32'hFFFF_FFFF, 32'd1, 4'b0010, 2, 32'd0, 1'b0, 1'b0);

    // Response backpressure with a second request waiting behind it
    intf.rsp_ready  = 1'b0;
    intf.req_opcode = 6'b000000;
    intf.req_funct  = 6'b100000;
    intf.req_shamt  = 5'd0;
    intf.req_rs     = 32'd100;
    intf.req_rt     = 32'd23;
    intf.req_valid  = 1'b1;
    step();
    intf.req_valid  = 1'b0;
    step();
    chk("bp_first_valid", 32'(intf.rsp_valid), 32'd1);
    intf.req_rs    = 32'd1;
    intf.req_rt    = 32'd2;
    intf.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", 32'(intf.rsp_valid), 32'd1);
      chk("bp_hold_result", intf.rsp_result, 32'd123);
      chk("bp_hold_req_ready", 32'(intf.req_ready), 32'd0);
    end
    intf.rsp_ready = 1'b1;
    step();
    chk("bp_after_hs_ready", 32'(intf.req_ready), 32'd1);
    chk("bp_after_hs_valid", 32'(intf.rsp_valid), 32'd0);
    step();
    intf.req_valid = 1'b0;
    chk("bp_second_accepted", 32'(intf.req_ready), 32'd0);
    step();
    chk("bp_second_valid", 32'(intf.rsp_valid), 32'd1);
    chk("bp_second_result", intf.rsp_result, 32'd3);
    step();
    chk("bp_second_done", 32'(intf.rsp_valid), 32'd0);

    // Reset while the operation sits in EXEC
    intf.req_rs    = 32'd7;
    intf.req_rt    = 32'd5;
    intf.req_valid = 1'b1;
    step();
    intf.req_valid = 1'b0;
    chk("rexec_busy", 32'(intf.req_ready), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rexec_req_ready", 32'(intf.req_ready), 32'd1);
    chk("rexec_rsp_valid", 32'(intf.rsp_valid), 32'd0);
    chk("rexec_result", intf.rsp_result, 32'd0);
    chk("rexec_alu_ctl", 32'(intf.alu_ctl), 32'd0);
    step();
    step();
    chk("rexec_no_rsp", 32'(intf.rsp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
